uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
UART receiver feeding a small buffer, on the board side of the serial link; it is the receive end of the CPU's Tx line.
- Samples the asynchronous serial line with 16x oversampling.
- Deserialises 8N1 frames, LSB first.
- Pushes good bytes into a first-word-fall-through FIFO, read by the host-interface controller with a simple pop strobe.
- Used in simulation benches and on the FPGA to capture program output.

Parameters:
SYS_CLK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate
FIFO_DEPTH, 8, receive buffer entries; power of two, minimum 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
rd_en  input  1  pop strobe; ignored when empty
rd_data  output  8  byte at FIFO head; valid while empty=0
empty  output  1  FIFO holds no bytes
full  output  1  FIFO holds FIFO_DEPTH bytes
count  output  $clog2(FIFO_DEPTH)+1  current occupancy
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: good byte dropped because FIFO full

Behaviour:
- Reset (async assert, sync release):
  - empty=1, full=0, count=0, rd_data=0.
  - frame_err=0, overrun=0.
  - Synchroniser flops=1, FSM=IDLE, all counters 0.
- rx goes through a 2-flop synchroniser; all decisions use the synchronised value.
- Oversample tick:
  - DIV = SYS_CLK_FREQ/(BAUD_RATE*16), integer division, minimum 1.
  - Free-running counter 0..DIV-1; tick is asserted on the cycle the counter equals DIV-1.
  - Counter is reset to 0 on entry to START, so the sample phase is aligned to the falling edge.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: synchronised rx==0 -> START; sample counter s=0.
  - START: s increments on each tick. At s==7 (mid start bit):
    - rx==0 -> DATA, s=0, bit index=0.
    - rx==1 -> IDLE (glitch rejected, nothing reported).
  - DATA: at each s==15 tick, shift rx into bit[index], LSB first. After index 7 -> STOP.
  - STOP: at s==15 tick (mid stop bit):
    - rx==1 -> push byte, return to IDLE.
    - rx==0 -> frame_err pulse, byte discarded, -> BREAK.
  - BREAK: wait for synchronised rx==1, then IDLE. A held-low line yields exactly one frame_err.
- Latency: empty deasserts the cycle after the clk edge that performs the stop-bit sample; rd_data is valid in that same cycle.
- FIFO:
  - Circular buffer with wrap-around read/write pointers and a separate occupancy counter.
  - rd_data is the head entry, combinational from storage.
  - Pop happens on a clk edge when rd_en=1 and empty=0. rd_en while empty: no effect.
  - Push while full and no pop: byte dropped, overrun pulses, contents unchanged.
  - Push and pop in the same cycle:
    - Both are performed and count is unchanged, including when full (no overrun).
    - When count==0 only the push occurs, because the pop is gated by empty.
  - full = (count==FIFO_DEPTH); empty = (count==0).
- Reset mid-frame aborts the frame and clears the FIFO; no partial byte is ever pushed.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Frame is 8E1; FSM adds a PARITY state between DATA and STOP, sampled at s==15.
  - Received even parity must equal the XOR of the 8 data bits.
  - On mismatch, the byte is discarded at STOP and a parity_err output (1 bit) pulses for one cycle, in the same cycle a push would have occurred.
  - Framing is still checked first: a bad stop bit reports frame_err only.
- Undefined: 8N1 only; no parity_err port.

Test Plan:
- Setup for all scenarios: SYS_CLK_FREQ=1600000, BAUD_RATE=100000 (DIV=1, 16 clk per bit), FIFO_DEPTH=4.
- Single frame 0xA5 -> empty falls the cycle after the stop-bit sample, rd_data=0xA5, count=1; pulse rd_en -> empty=1, count=0.
- 3-clk low glitch on idle rx -> FSM returns to IDLE; no push, no frame_err.
- Stop bit driven 0 on a byte 0x3C, then rx held low 40 clk -> exactly one frame_err pulse; FIFO stays empty; next good frame 0x11 is received.
- Five frames 0x01..0x05 with no reads -> full=1 after the 4th; overrun pulses once at the 5th; reads return 0x01,0x02,0x03,0x04.
- FIFO full (0x01..0x04), rd_en asserted in the cycle frame 0x05 pushes -> no overrun, count stays 4; drain yields 0x02..0x05.
- rst asserted mid-DATA of 0x77 with 2 bytes queued -> immediate empty=1, count=0; next frame 0x42 received correctly.
- With UART_RX_PARITY_EN: 0x07 sent with parity bit 0 -> parity_err pulse, no push; 0x07 with parity bit 1 -> pushed.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampled, 8N1 LSB first) feeding a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames and a parity_err pulse output.
module uart_rx_fifo #(
   parameter int SYS_CLK_FREQ = 100000000,
   parameter int BAUD_RATE    = 115200,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx,
   input  logic                          rd_en,
   output logic [7:0]                    rd_data,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                          parity_err,
`endif
   output logic                          overrun
);

   localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * 16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      BREAK
   } state_t;

   logic             rx_meta_reg, rx_sync_reg;
   logic [DIV_W-1:0] div_cnt_reg;
   logic             tick;
   logic             enter_start;

   state_t           state_reg, state_next;
   logic [3:0]       s_reg, s_next;
   logic [2:0]       idx_reg, idx_next;
   logic [7:0]       shift_reg, shift_next;
   logic             push;
   logic             frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
   logic             par_bad_reg, par_bad_next;
   logic             parity_err_reg, parity_err_next;
`endif

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             overrun_reg;
   logic             do_push, do_pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
      end else begin
         rx_meta_reg <= rx;
         rx_sync_reg <= rx_meta_reg;
      end
   end

   // Restarting the divider on the falling edge aligns sampling to the start bit.
   assign tick = (div_cnt_reg == DIV_W'(DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         div_cnt_reg <= '0;
      else if (enter_start || tick)
         div_cnt_reg <= '0;
      else
         div_cnt_reg <= div_cnt_reg + DIV_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         s_reg          <= '0;
         idx_reg        <= '0;
         shift_reg      <= '0;
         frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_reg    <= 1'b0;
         parity_err_reg <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         s_reg          <= s_next;
         idx_reg        <= idx_next;
         shift_reg      <= shift_next;
         frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
         par_bad_reg    <= par_bad_next;
         parity_err_reg <= parity_err_next;
`endif
      end
   end

   always_comb begin
      state_next      = state_reg;
      s_next          = s_reg;
      idx_next        = idx_reg;
      shift_next      = shift_reg;
      enter_start     = 1'b0;
      push            = 1'b0;
      frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_next    = par_bad_reg;
      parity_err_next = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (!rx_sync_reg) begin
               state_next  = START;
               s_next      = '0;
               enter_start = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               if (s_reg == 4'd7) begin
                  if (!rx_sync_reg) begin
                     state_next = DATA;
                     s_next     = '0;
                     idx_next   = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  s_next = s_reg + 4'd1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_reg == 4'd15) begin
                  shift_next[idx_reg] = rx_sync_reg;
                  s_next              = '0;
                  if (idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_next = PARITY;
`else
                     state_next = STOP;
`endif
                  end else begin
                     idx_next = idx_reg + 3'd1;
                  end
               end else begin
                  s_next = s_reg + 4'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (s_reg == 4'd15) begin
                  par_bad_next = (rx_sync_reg != ^shift_reg);
                  s_next       = '0;
                  state_next   = STOP;
               end else begin
                  s_next = s_reg + 4'd1;
               end
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (s_reg == 4'd15) begin
                  s_next = '0;
                  // Framing is judged before parity: a bad stop bit reports only frame_err.
                  if (rx_sync_reg) begin
                     state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                     if (par_bad_reg)
                        parity_err_next = 1'b1;
                     else
                        push = 1'b1;
`else
                     push = 1'b1;
`endif
                  end else begin
                     frame_err_next = 1'b1;
                     state_next     = BREAK;
                  end
               end else begin
                  s_next = s_reg + 4'd1;
               end
            end
         end
         BREAK: begin
            if (rx_sync_reg)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign do_pop  = rd_en && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg] <= shift_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         overrun_reg <= 1'b0;
      end else begin
         overrun_reg <= push && full && !do_pop;
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign empty     = (count_reg == '0);
   assign full      = (count_reg == CNT_W'(FIFO_DEPTH));
   assign count     = count_reg;
   assign rd_data   = empty ? 8'h00 : mem[rd_ptr_reg];
   assign frame_err = frame_err_reg;
   assign overrun   = overrun_reg;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_reg;
`endif

endmodule
